// File: rtl/spi_seq_pkg.sv
// spi_seq_pkg: shared states, timing constants and helpers for spi_flash_seq.
// ST_DUMMY exists only when SPI_SEQ_DUMMY_EN is defined.
package spi_seq_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SS_SETUP = 3'd1;
    localparam logic [2:0] ST_CMD      = 3'd2;
    localparam logic [2:0] ST_ADDR     = 3'd3;
`ifdef SPI_SEQ_DUMMY_EN
    localparam logic [2:0] ST_DUMMY    = 3'd4;
`endif
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_SS_HOLD  = 3'd6;

    localparam logic [1:0] B_IDLE      = 2'd0;
    localparam logic [1:0] B_ISSUE     = 2'd1;
    localparam logic [1:0] B_WAIT_BUSY = 2'd2;
    localparam logic [1:0] B_WAIT_DONE = 2'd3;

    localparam int SS_SETUP_CYC = 2;
    localparam int SS_HOLD_CYC  = 2;
    localparam int ADDR_BYTES   = 3;
    localparam logic [7:0] FILL_BYTE = 8'h00;

    // Address bytes go out big-endian: index 0 is addr[23:16].
    function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [1:0] i);
        return i == 2'd0 ? a[23:16] : i == 2'd1 ? a[15:8] : a[7:0];
    endfunction

endpackage

// File: rtl/spi_flash_seq_if.sv
// spi_flash_seq_if: request channel and read-data stream of spi_flash_seq.
interface spi_flash_seq_if #(parameter int LWIDTH = 8);

    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_op;
    logic [23:0]       req_addr;
    logic [LWIDTH-1:0] req_len;
    logic [7:0]        rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (output req_valid, req_op, req_addr, req_len, rd_ready,
                    input  req_ready, rd_data, rd_valid);

    modport slave  (input  req_valid, req_op, req_addr, req_len, rd_ready,
                    output req_ready, rd_data, rd_valid);

endinterface

// File: rtl/spi_seq_byte.sv
// spi_seq_byte: one-byte ISSUE/WAIT_BUSY/WAIT_DONE handshake with spi_core.
module spi_seq_byte
    import spi_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       core_done,
    input  logic [7:0] core_dout,
    output logic       core_cs,
    output logic       core_wr,
    output logic [7:0] core_din,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    logic [1:0] bs_q, bs_d;
    logic [7:0] din_q, din_d;

    // Advance through the core handshake; a new start may coincide with completion.
    always_comb begin
        byte_done = (bs_q == B_WAIT_DONE) && core_done;
        bs_d      = bs_q == B_ISSUE ? B_WAIT_BUSY :
                    (bs_q == B_WAIT_BUSY) && !core_done ? B_WAIT_DONE :
                    byte_done ? B_IDLE : bs_q;
        din_d     = start ? tx_byte : din_q;
        if (start) bs_d = B_ISSUE;
    end

    // State and the byte held on core_din until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            bs_q  <= B_IDLE;
            din_q <= '0;
        end else begin
            bs_q  <= bs_d;
            din_q <= din_d;
        end
    end

    assign core_cs  = bs_q == B_ISSUE;
    assign core_wr  = bs_q == B_ISSUE;
    assign core_din = din_q;
    assign rx_byte  = core_dout;

endmodule

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: flash read sequencer driving spi_core byte by byte and owning ss_n.
// Build option: SPI_SEQ_DUMMY_EN inserts one dummy byte after the address.
module spi_flash_seq
    import spi_seq_pkg::*;
#(
    parameter int LWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_flash_seq_if.slave        bus,
    output logic                  busy,
    output logic                  ss_n,
    output logic                  core_cs,
    output logic                  core_wr,
    output logic                  core_rd,
    output logic [7:0]            core_din,
    input  logic [7:0]            core_dout,
    input  logic                  core_done
);

    logic [2:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        op_q, op_d;
    logic [23:0]       addr_q, addr_d;
    logic [LWIDTH-1:0] len_q, len_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              start, byte_done;
    logic [7:0]        tx, rx_byte;

    spi_seq_byte u_byte (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tx_byte   (tx),
        .core_done (core_done),
        .core_dout (core_dout),
        .core_cs   (core_cs),
        .core_wr   (core_wr),
        .core_din  (core_din),
        .byte_done (byte_done),
        .rx_byte   (rx_byte)
    );

    // Reset forces ss_n high and blocks requests combinationally; a new request
    // also waits for the core to finish any byte abandoned by a reset.
    assign ss_n          = rst | (state_q == ST_IDLE);
    assign busy          = state_q != ST_IDLE;
    assign core_rd       = 1'b0;
    assign bus.req_ready = ~rst & (state_q == ST_IDLE) & core_done;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

    // Phase sequencing; the next byte is started in the same cycle the previous one completes.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op_d       = op_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rd_valid_d = rd_valid_q & ~bus.rd_ready;
        rd_data_d  = rd_data_q;
        start      = 1'b0;
        tx         = FILL_BYTE;
        case (state_q)
            ST_IDLE: if (bus.req_valid && bus.req_ready) begin
                op_d    = bus.req_op;
                addr_d  = bus.req_addr;
                len_d   = bus.req_len;
                idx_d   = '0;
                state_d = ST_SS_SETUP;
            end
            ST_SS_SETUP: if (idx_q == 2'(SS_SETUP_CYC - 1)) begin
                state_d = ST_CMD;
                start   = 1'b1;
                tx      = op_q;
            end else idx_d = idx_q + 2'd1;
            ST_CMD: if (byte_done) begin
                state_d = ST_ADDR;
                idx_d   = '0;
                start   = 1'b1;
                tx      = addr_byte(addr_q, 2'd0);
            end
            ST_ADDR: if (byte_done) begin
                if (idx_q != 2'(ADDR_BYTES - 1)) begin
                    idx_d = idx_q + 2'd1;
                    start = 1'b1;
                    tx    = addr_byte(addr_q, idx_q + 2'd1);
                end else begin
`ifdef SPI_SEQ_DUMMY_EN
                    state_d = ST_DUMMY;
                    start   = 1'b1;
`else
                    state_d = len_q != '0 ? ST_DATA : ST_SS_HOLD;
                    start   = len_q != '0;
                    idx_d   = '0;
`endif
                end
            end
`ifdef SPI_SEQ_DUMMY_EN
            ST_DUMMY: if (byte_done) begin
                state_d = len_q != '0 ? ST_DATA : ST_SS_HOLD;
                start   = len_q != '0;
                idx_d   = '0;
            end
`endif
            ST_DATA: if (byte_done) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rx_byte;
                len_d      = len_q - 1'b1;
            end else if (rd_valid_q && bus.rd_ready) begin
                if (len_q != '0) start = 1'b1;
                else begin
                    state_d = ST_SS_HOLD;
                    idx_d   = '0;
                end
            end
            ST_SS_HOLD: if (idx_q == 2'(SS_HOLD_CYC - 1)) state_d = ST_IDLE;
                        else idx_d = idx_q + 2'd1;
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase registers and the read-data output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: scoreboard bench for spi_flash_seq with a behavioural spi_core/flash model.
module tb_spi_flash_seq;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy, ss_n, core_cs, core_wr, core_rd;
    logic [7:0] core_din;
    logic [7:0] core_dout = 8'h00;
    logic       core_done = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_mosi[$];
    logic [7:0] exp_rd[$];
    logic [7:0] miso_q[$];

    spi_flash_seq_if #(.LWIDTH(8)) bus ();

    spi_flash_seq #(.LWIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .ss_n      (ss_n),
        .core_cs   (core_cs),
        .core_wr   (core_wr),
        .core_rd   (core_rd),
        .core_din  (core_din),
        .core_dout (core_dout),
        .core_done (core_done)
    );

    always #5 clk = ~clk;

    // spi_core + flash: a write starts a LAT+1 cycle byte; dout comes from miso_q.
    int         lat_cnt = 0;
    logic [7:0] shift   = 8'h00;
    always @(posedge clk) begin
        if (core_cs && core_wr && core_done) begin
            core_done <= 1'b0;
            lat_cnt   <= LAT;
            if (miso_q.size() != 0) shift <= miso_q.pop_front();
            else shift <= 8'hEE;
        end else if (!core_done) begin
            if (lat_cnt == 0) begin
                core_done <= 1'b1;
                core_dout <= shift;
            end else lat_cnt <= lat_cnt - 1;
        end
    end

    function automatic logic [7:0] dbyte(input logic [7:0] seed, input int i);
        return i[0] ? ~seed : seed ^ 8'(i);
    endfunction

    task automatic run_txn(input logic [7:0] op, input logic [23:0] addr, input int len,
                           input logic [7:0] seed, input int bp_idx, input int bp_cyc,
                           input bit keep_valid, input bit pre_acc);
        int n, cyc, e, nd, nrd, nrise, stall, first_wr, last_done, nhdr;
        bit prev_done, prev_rdv, stable, rdy_bad;
        logic [7:0] ex;
        nhdr = 4;
`ifdef SPI_SEQ_DUMMY_EN
        nhdr = 5;
`endif
        exp_mosi.push_back(op);
        exp_mosi.push_back(addr[23:16]);
        exp_mosi.push_back(addr[15:8]);
        exp_mosi.push_back(addr[7:0]);
`ifdef SPI_SEQ_DUMMY_EN
        exp_mosi.push_back(8'h00);
`endif
        for (int i = 0; i < nhdr; i++) miso_q.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < len; i++) begin
            exp_mosi.push_back(8'h00);
            exp_rd.push_back(dbyte(seed, i));
            miso_q.push_back(dbyte(seed, i));
        end
        if (!pre_acc) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = op;
            bus.req_addr  = addr;
            bus.req_len   = 8'(len);
            n = 0;
            while (!bus.req_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL req_accept: req_ready=%b required 1", bus.req_ready);
            end
        end
        @(negedge clk);
        if (!keep_valid) bus.req_valid = 1'b0;
        checks++;
        if (ss_n !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ss_n_low: ss_n=%b busy=%b required 0/1", ss_n, busy);
        end
        cyc = 0; e = -100; nd = 0; nrd = 0; nrise = 0; stall = 0; first_wr = -1; last_done = -100;
        prev_done = core_done; prev_rdv = bus.rd_valid; stable = 1'b1; rdy_bad = 1'b0;
        while (ss_n === 1'b0 && cyc < 5000) begin
            if (bus.rd_valid && nrd == bp_idx && stall < bp_cyc) begin
                bus.rd_ready = 1'b0;
                stall++;
                if (exp_rd.size() != 0 && bus.rd_data !== exp_rd[0]) stable = 1'b0;
            end else bus.rd_ready = 1'b1;
            if (core_wr) begin
                if (first_wr < 0) first_wr = cyc;
                ex = 8'hxx;
                if (exp_mosi.size() != 0) ex = exp_mosi.pop_front();
                checks++;
                if (core_din !== ex || core_cs !== 1'b1 || bus.rd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL mosi: din=%h cs=%b rd_valid=%b required din=%h cs=1 rd_valid=0",
                             core_din, core_cs, bus.rd_valid, ex);
                end
            end
            if (core_done && !prev_done) begin
                nd++;
                e = cyc;
                last_done = cyc;
            end
            if (bus.rd_valid && !prev_rdv) begin
                nrise++;
                checks++;
                if (last_done != cyc - 1 || nd <= nhdr) begin
                    errors++;
                    $display("FAIL rd_valid_rise: at cycle %0d after done cycle %0d byte %0d, required next cycle of a data byte",
                             cyc, last_done, nd);
                end
            end
            if (busy && bus.req_ready) rdy_bad = 1'b1;
            if (bus.rd_valid && bus.rd_ready) begin
                nrd++;
                e = cyc;
                ex = 8'hxx;
                if (exp_rd.size() != 0) ex = exp_rd.pop_front();
                checks++;
                if (bus.rd_data !== ex) begin
                    errors++;
                    $display("FAIL rd_data: got %h required %h", bus.rd_data, ex);
                end
            end
            prev_done = core_done;
            prev_rdv  = bus.rd_valid;
            @(negedge clk);
            cyc++;
        end
        bus.rd_ready = 1'b1;
        checks++;
        if (ss_n !== 1'b1 || cyc != e + 3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ss_hold: ss_n=%b busy=%b high at cycle %0d required 1/0 at cycle %0d",
                     ss_n, busy, cyc, e + 3);
        end
        checks++;
        if (first_wr != 2) begin
            errors++;
            $display("FAIL ss_setup: first core_wr at cycle %0d required 2", first_wr);
        end
        checks++;
        if (exp_mosi.size() != 0 || exp_rd.size() != 0 || nrise != len) begin
            errors++;
            $display("FAIL byte_count: mosi left %0d rd left %0d rd_valid rises %0d required 0/0/%0d",
                     exp_mosi.size(), exp_rd.size(), nrise, len);
        end
        checks++;
        if (rdy_bad) begin
            errors++;
            $display("FAIL busy_req_ready: req_ready=1 while busy required 0");
        end
        if (bp_cyc > 0) begin
            checks++;
            if (!stable || stall != bp_cyc) begin
                errors++;
                $display("FAIL bp_stable: stable=%b stalled %0d cycles required 1/%0d", stable, stall, bp_cyc);
            end
        end
        exp_mosi.delete();
        exp_rd.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ss_n !== 1'b1 || bus.req_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 ||
            busy !== 1'b0 || core_cs !== 1'b0 || core_wr !== 1'b0 || core_rd !== 1'b0 || core_din !== 8'h00) begin
            errors++;
            $display("FAIL reset_values: ss_n=%b req_ready=%b rd_valid=%b rd_data=%h busy=%b cs=%b wr=%b rd=%b din=%h required 1 0 0 00 0 0 0 0 00",
                     ss_n, bus.req_ready, bus.rd_valid, bus.rd_data, busy, core_cs, core_wr, core_rd, core_din);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: req_ready=%b required 1", bus.req_ready);
        end
    endtask

    task automatic test_plain_read();
        run_txn(8'h03, 24'h123456, 2, 8'hA5, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_zero_len();
        run_txn(8'h06, 24'hFEDCBA, 0, 8'h00, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_txn(8'h03, 24'h00ABCD, 3, 8'h3C, 0, 200, 1'b0, 1'b0);
    endtask

    task automatic test_req_while_busy();
        run_txn(8'h03, 24'h000F00, 2, 8'h96, -1, 0, 1'b1, 1'b0);
        checks++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL first_idle_accept: req_ready=%b busy=%b required 1/0", bus.req_ready, busy);
        end
        run_txn(8'h03, 24'h000F00, 2, 8'h69, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int n, nwr;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 8'h03;
        bus.req_addr  = 24'hABCDEF;
        bus.req_len   = 8'd2;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        nwr = 0;
        n = 0;
        while (nwr < 2 && n < 200) begin
            if (core_wr) nwr++;
            if (nwr < 2) begin
                @(negedge clk);
                n++;
            end
        end
        checks++;
        if (nwr != 2) begin
            errors++;
            $display("FAIL mid_byte2: saw %0d core_wr pulses required 2", nwr);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ss_n !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_immediate: ss_n=%b req_ready=%b required 1/0", ss_n, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ss_n !== 1'b1 || busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 ||
            core_wr !== 1'b0 || core_din !== 8'h00 || bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: ss_n=%b busy=%b rd_valid=%b rd_data=%h wr=%b din=%h req_ready=%b required 1 0 0 00 0 00 0",
                     ss_n, busy, bus.rd_valid, bus.rd_data, core_wr, core_din, bus.req_ready);
        end
        n = 0;
        while (!core_done && n < 100) begin
            checks++;
            if (bus.req_ready !== 1'b0) begin
                errors++;
                $display("FAIL drain_ready: req_ready=%b required 0 while core busy", bus.req_ready);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_done: req_ready=%b required 1 after core drains", bus.req_ready);
        end
        miso_q.delete();
        run_txn(8'h03, 24'h5A5A01, 2, 8'h0F, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_dummy();
`ifdef SPI_SEQ_DUMMY_EN
        run_txn(8'h0B, 24'h000010, 1, 8'hC3, -1, 0, 1'b0, 1'b0);
`else
        run_txn(8'h03, 24'h000010, 1, 8'hC3, -1, 0, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 8'h00;
        bus.req_addr  = 24'h0;
        bus.req_len   = 8'h00;
        bus.rd_ready  = 1'b1;
        test_reset();
        test_plain_read();
        test_zero_len();
        test_backpressure();
        test_req_while_busy();
        test_reset_mid();
        test_dummy();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
